// File: rtl/niosqs_debug_jtag_host_if.sv
// Command/response handshake bundle between a debug client and the JTAG host.
interface niosqs_debug_jtag_host_if #(
  parameter int DR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                resp_valid;
  logic                resp_ready;
  logic [DR_WIDTH-1:0] resp_data;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, resp_ready,
    input  cmd_ready, resp_valid, resp_data
  );
  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, resp_ready,
    output cmd_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/niosqs_debug_jtag_host.sv
// Virtual-JTAG initiator: runs one UIR/CDR/SDR/UDR scan per command and
// returns the captured tdo bits, with UIR skipped when the IR is unchanged.
module niosqs_debug_jtag_host #(
  parameter int DR_WIDTH = 38,
  parameter int TCK_HALF = 2
) (
  input  logic       clk,
  input  logic       reset,
  niosqs_debug_jtag_host_if.slave bus,
  output logic       vji_tck,
  output logic       vji_tdi,
  input  logic       vji_tdo,
  output logic [1:0] vji_ir_in,
  output logic       vji_uir,
  output logic       vji_cdr,
  output logic       vji_sdr,
  output logic       vji_udr,
  output logic       vji_rti
);
  localparam int CW = $clog2(2*TCK_HALF+1);
  localparam int BW = $clog2(DR_WIDTH+1);
  localparam logic [CW-1:0] RISE = CW'(TCK_HALF);
  localparam logic [CW-1:0] LAST = CW'(2*TCK_HALF-1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d, data_q, data_d, rdata_q, rdata_d;
  logic [1:0]          ir_q, ir_d;
  logic                known_q, known_d, tdi_q, tdi_d, rvalid_q, rvalid_d;
  logic                busy, rise, last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      ir_q     <= 2'b00;
      known_q  <= 1'b0;
      tdi_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      ir_q     <= ir_d;
      known_q  <= known_d;
      tdi_q    <= tdi_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign busy = (state_q == UIR) || (state_q == CDR) || (state_q == SDR) || (state_q == UDR);
  assign rise = busy && (cnt_q == RISE);
  assign last = cnt_q == LAST;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    ir_d     = ir_q;
    known_d  = known_q;
    tdi_d    = tdi_q;
    rvalid_d = rvalid_q;
    if (busy) cnt_d = last ? '0 : cnt_q + CW'(1);
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        data_d = bus.cmd_data;
        if (known_q && bus.cmd_ir == ir_q) state_d = CDR;
        else begin
          ir_d    = bus.cmd_ir;
          state_d = UIR;
        end
      end
      UIR: if (last) begin
        known_d = 1'b1;
        state_d = CDR;
      end
      CDR: if (last) begin
        shift_d = data_q;
        tdi_d   = data_q[0];
        bit_d   = '0;
        state_d = SDR;
      end
      SDR: begin
        if (rise) shift_d = {vji_tdo, shift_q[DR_WIDTH-1:1]};
        // tdi is re-registered at the period boundary so it only moves while tck is low
        if (last) begin
          if (bit_q == BW'(DR_WIDTH-1)) begin
            tdi_d   = 1'b0;
            state_d = UDR;
          end else begin
            bit_d = bit_q + BW'(1);
            tdi_d = shift_d[0];
          end
        end
      end
      UDR: if (last) begin
        rdata_d  = shift_q;
        rvalid_d = 1'b1;
        state_d  = DONE;
      end
      DONE: if (rvalid_q && bus.resp_ready) begin
        rvalid_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign vji_tck        = busy && (cnt_q >= RISE);
  assign vji_tdi        = tdi_q;
  assign vji_ir_in      = ir_q;
  assign vji_uir        = state_q == UIR;
  assign vji_cdr        = state_q == CDR;
  assign vji_sdr        = state_q == SDR;
  assign vji_udr        = state_q == UDR;
  assign vji_rti        = (state_q == IDLE) || (state_q == DONE);
  assign bus.cmd_ready  = state_q == IDLE;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_data  = rdata_q;
endmodule

// File: tb/tb_niosqs_debug_jtag_host.sv
// Random scans on a default-size and an 8-bit/TCK_HALF=1 host, checked
// against an IR-tracking model and a tdo pattern source.
module tb_niosqs_debug_jtag_host;
  localparam int W = 38, H = 2, SW = 8, SH = 1, LIM = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, cv, rr, sel, loop, tdo_r;
  logic [1:0]   cir;
  logic [W-1:0] cdat, pat;
  int           checks = 0, errors = 0, hot_err = 0, tdi_err = 0;
  bit           known_m [2];
  logic [1:0]   ir_m [2];

  niosqs_debug_jtag_host_if #(.DR_WIDTH(W))  bif ();
  niosqs_debug_jtag_host_if #(.DR_WIDTH(SW)) sif ();

  logic       b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti;
  logic       s_tck, s_tdi, s_tdo, s_uir, s_cdr, s_sdr, s_udr, s_rti;
  logic [1:0] b_ir, s_ir;

  assign bif.cmd_valid  = cv & ~sel;
  assign bif.cmd_ir     = cir;
  assign bif.cmd_data   = cdat;
  assign bif.resp_ready = rr & ~sel;
  assign sif.cmd_valid  = cv & sel;
  assign sif.cmd_ir     = cir;
  assign sif.cmd_data   = cdat[SW-1:0];
  assign sif.resp_ready = rr & sel;
  assign b_tdo = loop ? b_tdi : tdo_r;
  assign s_tdo = loop ? s_tdi : tdo_r;

  niosqs_debug_jtag_host #(.DR_WIDTH(W), .TCK_HALF(H)) u_big (
    .clk(clk), .reset(rst), .bus(bif),
    .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo), .vji_ir_in(b_ir),
    .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti));

  niosqs_debug_jtag_host #(.DR_WIDTH(SW), .TCK_HALF(SH)) u_small (
    .clk(clk), .reset(rst), .bus(sif),
    .vji_tck(s_tck), .vji_tdi(s_tdi), .vji_tdo(s_tdo), .vji_ir_in(s_ir),
    .vji_uir(s_uir), .vji_cdr(s_cdr), .vji_sdr(s_sdr), .vji_udr(s_udr), .vji_rti(s_rti));

  logic         m_tck, m_tdi, m_uir, m_sdr, m_rti, m_ready, m_rvalid;
  logic [1:0]   m_ir;
  logic [W-1:0] m_rdata;
  assign m_tck    = sel ? s_tck : b_tck;
  assign m_tdi    = sel ? s_tdi : b_tdi;
  assign m_uir    = sel ? s_uir : b_uir;
  assign m_sdr    = sel ? s_sdr : b_sdr;
  assign m_rti    = sel ? s_rti : b_rti;
  assign m_ir     = sel ? s_ir  : b_ir;
  assign m_ready  = sel ? sif.cmd_ready  : bif.cmd_ready;
  assign m_rvalid = sel ? sif.resp_valid : bif.resp_valid;
  assign m_rdata  = sel ? W'(sif.resp_data) : bif.resp_data;

  always @(negedge clk) if (!rst) begin
    if ($countones({b_uir, b_cdr, b_sdr, b_udr, b_rti}) > 1) hot_err++;
    if ($countones({s_uir, s_cdr, s_sdr, s_udr, s_rti}) > 1) hot_err++;
    if ((!b_sdr && b_tdi) || (!s_sdr && s_tdi)) tdi_err++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input bit s, input logic [1:0] ir, input logic [W-1:0] data,
                         input logic [W-1:0] p, input bit lp, input int abort_at, input int hold);
    int w, h, lat, uirc, rises, tdih, n, bad;
    bit exp_uir, ptck;
    logic [W-1:0] mask, d0;
    w = s ? SW : W;
    h = s ? SH : H;
    mask = (W'(1) << w) - W'(1);
    exp_uir = !(known_m[s] && ir_m[s] == ir);
    @(negedge clk);
    sel = s; loop = lp; pat = p; cir = ir; cdat = data; cv = 1'b1; tdo_r = p[0];
    n = 0;
    while (!m_ready && n < LIM) begin @(negedge clk); n++; end
    if (!m_ready) begin
      chk("accept", {63'd0, m_ready}, 64'd1);
      cv = 1'b0;
      return;
    end
    lat = 0; uirc = 0; rises = 0; tdih = 0; ptck = 1'b0;
    do begin
      @(negedge clk);
      cv = 1'b0;
      lat++;
      if (m_uir) uirc++;
      if (m_sdr && m_tck && !ptck) rises++;
      if (m_sdr && m_tdi) tdih++;
      ptck = m_tck;
      if (!m_tck) tdo_r = (rises < w) ? pat[rises] : 1'b0;
      if (abort_at >= 0 && m_sdr && rises == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rti", {63'd0, m_rti}, 64'd1);
        chk("abort_tck", {63'd0, m_tck}, 64'd0);
        chk("abort_rdy", {63'd0, m_ready}, 64'd1);
        chk("abort_ir", {62'd0, m_ir}, 64'd0);
        known_m[0] = 1'b0; known_m[1] = 1'b0;
        bad = 0;
        repeat (300) begin @(negedge clk); if (m_rvalid || !m_rti) bad++; end
        chk("abort_noresp", 64'(bad), 64'd0);
        return;
      end
    end while (!m_rvalid && lat < LIM);
    chk("latency", 64'(lat), 64'(((exp_uir ? 3 : 2) + w) * 2 * h + 1));
    chk("uir_cycles", 64'(uirc), exp_uir ? 64'(2 * h) : 64'd0);
    chk("sdr_rises", 64'(rises), 64'(w));
    chk("tdi_hi", 64'(tdih), 64'($countones(data & mask) * 2 * h));
    chk("ir_in", {62'd0, m_ir}, {62'd0, ir});
    chk("rdata", 64'(m_rdata), 64'((lp ? data : p) & mask));
    known_m[s] = 1'b1;
    ir_m[s] = ir;
    if (hold > 0) begin
      cv = 1'b1;
      d0 = m_rdata;
      bad = 0;
      repeat (hold) begin
        @(negedge clk);
        if (m_ready || m_rdata !== d0 || !m_rvalid) bad++;
      end
      chk("backpressure", 64'(bad), 64'd0);
      cv = 1'b0;
    end
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    chk("rvalid_clr", {63'd0, m_rvalid}, 64'd0);
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  initial begin
    rst = 1'b1; cv = 1'b1; rr = 1'b0; sel = 1'b0; loop = 1'b1; tdo_r = 1'b0;
    cir = 2'b11; cdat = '1; pat = '0;
    known_m[0] = 1'b0; known_m[1] = 1'b0; ir_m[0] = 2'b00; ir_m[1] = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_tck", {63'd0, b_tck}, 64'd0);
    chk("rst_tdi", {63'd0, b_tdi}, 64'd0);
    chk("rst_ir", {62'd0, b_ir}, 64'd0);
    chk("rst_flags", {59'd0, b_uir, b_cdr, b_sdr, b_udr, b_rti}, 64'd1);
    chk("rst_ready", {63'd0, bif.cmd_ready}, 64'd1);
    chk("rst_rvalid", {63'd0, bif.resp_valid}, 64'd0);
    chk("rst_rdata", 64'(bif.resp_data), 64'd0);
    rst = 1'b0; cv = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ignored", {62'd0, b_uir, b_rti}, 64'd1);

    run_cmd(0, 2'b01, 38'h2A_5A5A_5A5A, '0, 1, -1, 0);
    run_cmd(0, 2'b01, rnd(), '0, 1, -1, 0);
    run_cmd(0, 2'b10, rnd(), '0, 1, -1, 0);
    run_cmd(0, 2'b10, '0, '1, 0, -1, 0);
    run_cmd(0, 2'b10, rnd(), rnd(), 0, -1, 50);
    run_cmd(0, 2'b10, rnd(), rnd(), 0, 20, 0);
    run_cmd(0, 2'b10, rnd(), rnd(), 1, -1, 0);
    run_cmd(1, 2'b01, rnd(), rnd(), 1, -1, 0);
    run_cmd(1, 2'b01, rnd(), rnd(), 0, -1, 0);

    for (int i = 0; i < 24; i++)
      run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd(), rnd(),
              1'($urandom_range(0, 1)), -1, ($urandom_range(0, 7) == 0) ? 10 : 0);

    chk("onehot", 64'(hot_err), 64'd0);
    chk("tdi_idle", 64'(tdi_err), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
